// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the dual-clock FIFO: credit-limited requests, a circular
// skid buffer for returned words, and a valid/ready output stream.
module fifo_rd_stream #(
  parameter int DWIDTH = 16,
  parameter int SWIDTH = 2
) (
  input  logic              rclk,
  input  logic              arst_n,
  output logic              rrq,
  input  logic              rempty,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              rdv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [SWIDTH:0]   level,
  output logic              err
);

  localparam int              D     = 1 << SWIDTH;
  localparam logic [SWIDTH:0] DFULL = (SWIDTH+1)'(D);

  logic              run_q, run_d;
  logic [SWIDTH:0]   pend_q, pend_d;
  logic [SWIDTH:0]   cnt_q, cnt_d;
  logic [SWIDTH-1:0] wptr_q, wptr_d;
  logic [SWIDTH-1:0] rptr_q, rptr_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] mem_q [D];

  logic [SWIDTH+1:0] credit_used;
  logic              req_acc, pop, push, unsol, full, ret;

  always_comb begin
    // Credit uses registered state only, so rrq never depends on rempty/rdv/out_ready.
    credit_used = {1'b0, pend_q} + {1'b0, cnt_q};
    rrq         = run_q & (credit_used < (SWIDTH+2)'(D));
    out_valid   = (cnt_q != '0);
    out_data    = out_valid ? mem_q[rptr_q] : '0;
    level       = cnt_q;
    err         = err_q;

    req_acc = rrq & ~rempty;
    pop     = out_valid & out_ready;
    full    = (cnt_q == DFULL);
    unsol   = rdv & (pend_q == '0);
    ret     = rdv & ~unsol;
    // An unsolicited word never takes a slot freed by a same-cycle pop.
    push    = rdv & (~full | (pop & ~unsol));

    run_d  = 1'b1;
    pend_d = pend_q + (SWIDTH+1)'(req_acc) - (SWIDTH+1)'(ret);
    cnt_d  = cnt_q + (SWIDTH+1)'(push) - (SWIDTH+1)'(pop);
    wptr_d = wptr_q + SWIDTH'(push);
    rptr_d = rptr_q + SWIDTH'(pop);
    err_d  = err_q | unsol | (rdv & full & ~pop);
  end

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      run_q  <= 1'b0;
      pend_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  // Buffer storage carries no reset; out_data is masked while the buffer is empty.
  always_ff @(posedge rclk) begin
    if (push) mem_q[wptr_q] <= rdata;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with in-order random-latency returns,
// randomized backpressure, and a word-sequence scoreboard.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rrq;
  logic        rempty = 1'b1;
  logic [15:0] rdata = '0;
  logic        rdv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  level;
  logic        err;

  fifo_rd_stream #(.DWIDTH(16), .SWIDTH(2)) dut (
    .rclk(rclk), .arst_n(arst_n), .rrq(rrq), .rempty(rempty), .rdata(rdata),
    .rdv(rdv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .err(err)
  );

  always #5 rclk = ~rclk;

  typedef struct { int due; logic [15:0] d; } ret_t;

  logic [15:0] src_q[$];
  ret_t        ret_q[$];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int cyc = 0, last_due = 0, acc_cnt = 0, mcnt = 0, lvl_bad = 0, inv_bad = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;
  bit inj = 0;
  logic [15:0] inj_d = '0;
  int n_checks = 0, n_fail = 0;

  // One clock of the FIFO/sink model: observe at negedge, advance after posedge.
  task automatic cycle();
    bit acc, pop, pushed;
    int l, due;
    logic [15:0] w;
    @(negedge rclk);
    if (level !== 3'(mcnt)) lvl_bad++;
    if (int'(level) + ret_q.size() + int'(rdv) > 4) inv_bad++;
    acc = rrq & ~rempty;
    pop = out_valid & out_ready;
    if (pop) begin got_q.push_back(out_data); got_cyc.push_back(cyc); end
    pushed = rdv && (mcnt < 4 || pop);
    mcnt = mcnt + int'(pushed) - int'(pop);
    @(posedge rclk); #1;
    cyc++;
    if (acc) begin
      w = src_q.pop_front();
      acc_cnt++;
      l = $urandom_range(lat_max, lat_min);
      due = cyc + l - 1;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      ret_q.push_back('{due, w});
    end
    rdv = 1'b0;
    if (inj) begin
      rdv = 1'b1; rdata = inj_d; inj = 0;
    end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      rdv = 1'b1; rdata = ret_q[0].d; void'(ret_q.pop_front());
    end
    rempty = (src_q.size() == 0);
    out_ready = ($urandom_range(99, 0) < rdy_pct);
  endtask

  task automatic clear_models();
    src_q.delete(); ret_q.delete(); got_q.delete(); got_cyc.delete();
    mcnt = 0; last_due = 0; acc_cnt = 0; inj = 0;
    rdv = 1'b0; rempty = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    clear_models();
    repeat (2) @(posedge rclk);
    #1;
    if (rrq !== 1'b0) begin n_fail++; $display("FAIL reset_rrq: got %b expected 0", rrq); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++;
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++;
  endtask

  task automatic test_basic();
    int n;
    lat_min = 1; lat_max = 1; rdy_pct = 100; out_ready = 1'b1;
    src_q = '{16'h0001, 16'h0002, 16'h0003};
    rempty = 1'b0;
    arst_n = 1'b1;
    #1;
    if (rrq !== 1'b0) begin n_fail++; $display("FAIL basic_rrq_release: got %b expected 0", rrq); end
    n_checks++;
    cycle();
    if (rrq !== 1'b1) begin n_fail++; $display("FAIL basic_rrq_after_run: got %b expected 1", rrq); end
    n_checks++;
    n = 0;
    while (got_q.size() < 3 && n < 30) begin cycle(); n++; end
    repeat (2) cycle();
    if (got_q.size() != 3 || got_q[0] !== 16'h0001 || got_q[1] !== 16'h0002 || got_q[2] !== 16'h0003) begin
      n_fail++; $display("FAIL basic_sequence: got %0d words expected 0001 0002 0003", got_q.size());
    end
    n_checks++;
    if (got_cyc.size() != 3 || got_cyc[2] - got_cyc[0] != 2) begin
      n_fail++; $display("FAIL basic_consecutive: got %0d words not on 3 consecutive cycles", got_cyc.size());
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL basic_level: got %0d expected 0", level); end
    n_checks++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    int n, bad;
    rdy_pct = 0; out_ready = 1'b0;
    got_q.delete(); got_cyc.delete(); acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'($urandom));
      src_q.push_back(exp_q[i]);
    end
    rempty = 1'b0;
    repeat (15) cycle();
    if (acc_cnt != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", acc_cnt); end
    n_checks++;
    if (rrq !== 1'b0) begin n_fail++; $display("FAIL bp_rrq: got %b expected 0", rrq); end
    n_checks++;
    if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d expected 4", level); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head: got %b/%h expected 1/%h", out_valid, out_data, exp_q[0]);
    end
    n_checks++;
    rdy_pct = 100; out_ready = 1'b1;
    n = 0;
    while (got_q.size() < 10 && n < 100) begin cycle(); n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    if (got_q.size() != 10 || bad != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d words, %0d wrong, expected 10 in order", got_q.size(), bad);
    end
    n_checks++;
    repeat (3) cycle();
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    int sent, n, bad;
    lat_min = 1; lat_max = 5; rdy_pct = 50;
    got_q.delete(); got_cyc.delete();
    lvl_bad = 0; inv_bad = 0; sent = 0; n = 0;
    while (got_q.size() < 200 && n < 5000) begin
      if (sent < 200 && $urandom_range(1, 0) == 1) begin
        exp_q.push_back(16'($urandom));
        src_q.push_back(exp_q[sent]);
        sent++;
        rempty = 1'b0;
      end
      cycle();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 200; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    if (got_q.size() != 200) begin n_fail++; $display("FAIL rnd_count: got %0d expected 200", got_q.size()); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rnd_order: got %0d wrong words expected 0", bad); end
    n_checks++;
    if (inv_bad != 0) begin n_fail++; $display("FAIL rnd_credit: got %0d cycles over 4 expected 0", inv_bad); end
    n_checks++;
    if (lvl_bad != 0) begin n_fail++; $display("FAIL rnd_level: got %0d level mismatches expected 0", lvl_bad); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b expected 0", err); end
    n_checks++;
    rdy_pct = 100;
    repeat (10) cycle();
  endtask

  task automatic test_empty();
    int hi, ov, n;
    lat_min = 2; lat_max = 2; rdy_pct = 100;
    hi = 0; ov = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (rrq === 1'b1) hi++;
      if (out_valid !== 1'b0) ov++;
    end
    if (hi != 20) begin n_fail++; $display("FAIL empty_rrq: got %0d cycles high expected 20", hi); end
    n_checks++;
    if (ov != 0 || level !== 3'd0) begin
      n_fail++; $display("FAIL empty_idle: got %0d valid cycles level %0d expected 0/0", ov, level);
    end
    n_checks++;
    src_q.push_back(16'hBEEF);
    rempty = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin cycle(); n++; end
    if (n > 3) begin n_fail++; $display("FAIL empty_latency: got %0d cycles expected <= 3", n); end
    n_checks++;
    if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL empty_data: got %h expected beef", out_data); end
    n_checks++;
    repeat (5) cycle();
  endtask

  task automatic test_unsolicited();
    rdy_pct = 0; out_ready = 1'b0;
    if (err !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL unsol_pre: got err %b level %0d expected 0/0", err, level);
    end
    n_checks++;
    inj_d = 16'hDEAD; inj = 1;
    cycle();
    cycle();
    if (err !== 1'b1) begin n_fail++; $display("FAIL unsol_err: got %b expected 1", err); end
    n_checks++;
    if (level !== 3'd1) begin n_fail++; $display("FAIL unsol_level: got %0d expected 1", level); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hDEAD) begin
      n_fail++; $display("FAIL unsol_data: got %b/%h expected 1/dead", out_valid, out_data);
    end
    n_checks++;
    repeat (5) cycle();
    if (err !== 1'b1) begin n_fail++; $display("FAIL unsol_sticky: got %b expected 1", err); end
    n_checks++;
  endtask

  task automatic test_midreset();
    int n;
    logic [15:0] late;
    arst_n = 1'b0;
    clear_models();
    repeat (2) @(posedge rclk);
    #1;
    if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b expected 0", err); end
    n_checks++;
    lat_min = 1; lat_max = 1; rdy_pct = 0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(16'h0A00 + 16'(i));
    rempty = 1'b0;
    arst_n = 1'b1;
    n = 0;
    while (!(level === 3'd3 && ret_q.size() + int'(rdv) == 1) && n < 20) begin cycle(); n++; end
    if (level !== 3'd3) begin n_fail++; $display("FAIL mid_setup_level: got %0d expected 3", level); end
    n_checks++;
    late = (rdv === 1'b1) ? rdata : ret_q[0].d;
    #2;
    arst_n = 1'b0;
    #1;
    if (rrq !== 1'b0) begin n_fail++; $display("FAIL mid_rrq: got %b expected 0", rrq); end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      n_fail++; $display("FAIL mid_out: got %b/%h expected 0/0000", out_valid, out_data);
    end
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
    n_checks++;
    clear_models();
    @(posedge rclk); #1;
    arst_n = 1'b1;
    inj_d = late; inj = 1;
    cycle();
    cycle();
    if (err !== 1'b1) begin n_fail++; $display("FAIL mid_late_err: got %b expected 1", err); end
    n_checks++;
    if (level !== 3'd1 || out_data !== late) begin
      n_fail++; $display("FAIL mid_late_word: got %0d/%h expected 1/%h", level, out_data, late);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_empty();
    test_unsolicited();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
